// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage (32 cycles/op + done cycle).
// Optional MULDIV_EARLY_OUT_EN: trivial cases (div-by-zero, signed overflow, zero multiply operand) finish in one cycle.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_E,
  input  logic [2:0]      ctrl_muldiv_op_E,
  input  logic [XLEN-1:0] srcA_E,
  input  logic [XLEN-1:0] srcB_E,
  input  logic            flush_E,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            neg_q;
  logic            divz_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            launch_w;
  logic            op_signed_a_w;
  logic            op_signed_b_w;
  logic            sign_a_w;
  logic            sign_b_w;
  logic [XLEN-1:0] mag_a_w;
  logic [XLEN-1:0] mag_b_w;
  logic            neg_w;
  logic            divz_w;

  always_comb begin
    op_signed_a_w = (ctrl_muldiv_op_E != OP_MULHU) && (ctrl_muldiv_op_E != OP_DIVU) &&
                    (ctrl_muldiv_op_E != OP_REMU);
    op_signed_b_w = op_signed_a_w && (ctrl_muldiv_op_E != OP_MULHSU);
    sign_a_w      = op_signed_a_w & srcA_E[XLEN-1];
    sign_b_w      = op_signed_b_w & srcB_E[XLEN-1];
    mag_a_w       = sign_a_w ? (~srcA_E + 1'b1) : srcA_E;
    mag_b_w       = sign_b_w ? (~srcB_E + 1'b1) : srcB_E;
    // Remainder takes the dividend's sign; quotient and product take the XOR.
    neg_w         = (ctrl_muldiv_op_E[2] && ctrl_muldiv_op_E[1]) ? sign_a_w : (sign_a_w ^ sign_b_w);
    divz_w        = ctrl_muldiv_op_E[2] && (srcB_E == '0);
    launch_w      = start_E && !flush_E && (state_q != S_RUN);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            ovf_w;
  logic            early_w;
  logic [XLEN-1:0] early_res_w;

  always_comb begin
    ovf_w   = ((ctrl_muldiv_op_E == OP_DIV) || (ctrl_muldiv_op_E == OP_REM)) &&
              (srcA_E == {1'b1, {(XLEN-1){1'b0}}}) && (srcB_E == '1);
    early_w = (!ctrl_muldiv_op_E[2] && ((srcA_E == '0) || (srcB_E == '0))) || divz_w || ovf_w;
    if (!ctrl_muldiv_op_E[2]) begin
      early_res_w = '0;
    end else if (divz_w) begin
      early_res_w = ctrl_muldiv_op_E[1] ? srcA_E : '1;
    end else begin
      early_res_w = ctrl_muldiv_op_E[1] ? '0 : srcA_E;
    end
  end
`endif

  // One shift-add (multiply) or restoring-subtract (divide) step over hi/lo.
  logic [XLEN:0]     sum_w;
  logic [XLEN:0]     shl_w;
  logic [XLEN-1:0]   diff_w;
  logic              ge_w;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;
  logic [2*XLEN-1:0] prod_w;
  logic [XLEN-1:0]   quo_rem_w;
  logic [XLEN-1:0]   result_d;

  always_comb begin
    sum_w  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    shl_w  = {hi_q, lo_q[XLEN-1]};
    // A set carry-out bit means the shifted remainder already exceeds any divisor.
    diff_w = shl_w[XLEN-1:0] - b_q;
    ge_w   = shl_w[XLEN] || (shl_w[XLEN-1:0] >= b_q);
    if (op_q[2]) begin
      hi_d = ge_w ? diff_w : shl_w[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge_w};
    end else begin
      hi_d = sum_w[XLEN:1];
      lo_d = {sum_w[0], lo_q[XLEN-1:1]};
    end

    prod_w = {hi_d, lo_d};
    if (neg_q) prod_w = ~prod_w + 1'b1;
    quo_rem_w = op_q[1] ? hi_d : lo_d;
    if (neg_q) quo_rem_w = ~quo_rem_w + 1'b1;

    if (!op_q[2]) begin
      result_d = (op_q == OP_MUL) ? prod_w[XLEN-1:0] : prod_w[2*XLEN-1:XLEN];
    end else if (divz_q && !op_q[1]) begin
      result_d = '1;
    end else begin
      result_d = quo_rem_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_E) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (launch_w) begin
        op_q    <= ctrl_muldiv_op_E;
        hi_q    <= '0;
        count_q <= '0;
        neg_q   <= neg_w;
        divz_q  <= divz_w;
        if (ctrl_muldiv_op_E[2]) begin
          b_q  <= mag_b_w;
          lo_q <= mag_a_w;
        end else begin
          b_q  <= mag_a_w;
          lo_q <= mag_b_w;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (early_w) begin
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= early_res_w;
        end else begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
`else
        state_q <= S_RUN;
        busy_q  <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_RUN: begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q + CW'(1);
            if (count_q == CW'(XLEN-1)) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= result_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases, flush/reset/back-to-back, random ops vs. arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [2:0]  ctrl_muldiv_op_E;
  logic [31:0] srcA_E;
  logic [31:0] srcB_E;
  logic        flush_E;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_E          (start_E),
    .ctrl_muldiv_op_E (ctrl_muldiv_op_E),
    .srcA_E           (srcA_E),
    .srcB_E           (srcB_E),
    .flush_E          (flush_E),
    .busy             (busy),
    .done             (done),
    .result           (result)
  );

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib, q;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    r  = '0;
    case (o)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = ia / ib; r = q; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin q = ia % ib; r = q; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_early(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[2] && (a == 0 || b == 0)) return 1'b1;
    if (o[2] && b == 0) return 1'b1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n, nbusy, exp_lat;
    logic [31:0] exp;
    exp     = model(o, a, b);
    exp_lat = is_early(o, a, b) ? 1 : 33;
    @(negedge clk);
    start_E = 1'b1; ctrl_muldiv_op_E = o; srcA_E = a; srcB_E = b;
    @(posedge clk); #1;
    start_E = 1'b0; ctrl_muldiv_op_E = 3'($urandom); srcA_E = $urandom; srcB_E = $urandom;
    n = 0; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin n = c; break; end
      if (busy) nbusy++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    chk({tag, " result"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    int n, nbusy, ndone;
    logic [2:0]  o;
    logic [31:0] a, b;

    reset = 1'b1; start_E = 1'b0; flush_E = 1'b0;
    ctrl_muldiv_op_E = '0; srcA_E = '0; srcB_E = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", result, 0);
    reset = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "MUL -3*7");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, "MULH -3*7");
    run_op(3'd3, 32'hFFFF_FFFD, 32'd7, "MULHU -3*7");
    run_op(3'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "MULHSU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
    run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, "REMU 100/7");
    run_op(3'd5, 32'd5, 32'd0, "DIVU 5/0");
    run_op(3'd6, 32'd5, 32'd0, "REM 5/0");
    run_op(3'd4, 32'd5, 32'd0, "DIV 5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
    run_op(3'd0, 32'd0, 32'h1234_5678, "MUL zero");

    // Reset held two cycles in the middle of an operation.
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "MUL pre-reset");
    @(negedge clk);
    start_E = 1'b1; ctrl_muldiv_op_E = 3'd5; srcA_E = 32'd100; srcB_E = 32'd7;
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrun reset busy", 32'(busy), 0);
    chk("midrun reset done", 32'(done), 0);
    chk("midrun reset result", result, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrun reset no done", 32'(ndone), 0);

    // Flush in cycle 10 of a DIV, with a competing start in the same cycle.
    run_op(3'd7, 32'd100, 32'd7, "REMU pre-flush");
    @(negedge clk);
    start_E = 1'b1; ctrl_muldiv_op_E = 3'd4; srcA_E = 32'hFFFF_FFF9; srcB_E = 32'd2;
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush busy before", 32'(busy), 1);
    flush_E = 1'b1; start_E = 1'b1; ctrl_muldiv_op_E = 3'd5; srcA_E = 32'd100; srcB_E = 32'd7;
    @(posedge clk); #1;
    flush_E = 1'b0; start_E = 1'b0;
    @(negedge clk);
    chk("flush busy after", 32'(busy), 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("flush no done/busy", 32'(ndone), 0);
    chk("flush result held", result, last_res);

    // Back-to-back: start held during the DONE cycle.
    @(negedge clk);
    start_E = 1'b1; ctrl_muldiv_op_E = 3'd0; srcA_E = 32'hFFFF_FFFD; srcB_E = 32'd7;
    @(posedge clk); #1;
    start_E = 1'b0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin n = c; break; end
    end
    chk("b2b first latency", 32'(n), 33);
    chk("b2b first result", result, 32'hFFFF_FFEB);
    start_E = 1'b1; ctrl_muldiv_op_E = 3'd3; srcA_E = 32'hFFFF_FFFF; srcB_E = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start_E = 1'b0; srcA_E = $urandom; srcB_E = $urandom;
    n = 0; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin n = c; break; end
      if (busy) nbusy++;
    end
    chk("b2b second latency", 32'(n), 33);
    chk("b2b second busy", 32'(nbusy), 32);
    chk("b2b second result", result, 32'hFFFF_FFFE);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 200));
        default: ;
      endcase
      run_op(o, a, b, $sformatf("rand%0d op%0d", i, o));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
